axi_lite_arbiter: RTL and testbench

- Parametrised N-master to 1-slave AXI4-lite arbiter with round-robin grant and both read and write channels.
- Sits between the core's bus masters (IFU fetch, LSU load/store, and later DMA/debug) and the single memory slave (DRAM model or SoC bus).
- One transaction is in flight at a time.
- Generalises the current single-master, read-only IFU-to-DRAM link to N masters with write support.

---
 rtl/axi_lite_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: N-master to 1-slave AXI4-lite arbiter with a round-robin grant.
// One transaction (read or write) is in flight at a time, and every transaction
// returns through IDLE, where the next master is chosen.
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   m_ar*/m_r*           per-master read address / read data channels (packed per master)
//   m_aw*/m_w*/m_b*      per-master write address / write data / write response channels
//   s_ar*/s_r*           slave-side read channels
//   s_aw*/s_w*/s_b*      slave-side write channels
//   grant                index of the currently granted master (debug)
//   busy                 high whenever the arbiter is not in IDLE
module axi_lite_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    // Master-side read channels
    input  logic [NUM_MASTERS*ADDR_W-1:0]       m_araddr,
    input  logic [NUM_MASTERS-1:0]              m_arvalid,
    output logic [NUM_MASTERS-1:0]              m_arready,
    output logic [DATA_W-1:0]                   m_rdata,
    output logic [1:0]                          m_rresp,
    output logic [NUM_MASTERS-1:0]              m_rvalid,
    input  logic [NUM_MASTERS-1:0]              m_rready,
    // Master-side write channels
    input  logic [NUM_MASTERS*ADDR_W-1:0]       m_awaddr,
    input  logic [NUM_MASTERS-1:0]              m_awvalid,
    output logic [NUM_MASTERS-1:0]              m_awready,
    input  logic [NUM_MASTERS*DATA_W-1:0]       m_wdata,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0]   m_wstrb,
    input  logic [NUM_MASTERS-1:0]              m_wvalid,
    output logic [NUM_MASTERS-1:0]              m_wready,
    output logic [1:0]                          m_bresp,
    output logic [NUM_MASTERS-1:0]              m_bvalid,
    input  logic [NUM_MASTERS-1:0]              m_bready,
    // Slave-side read channels
    output logic [ADDR_W-1:0]                   s_araddr,
    output logic                                s_arvalid,
    input  logic                                s_arready,
    input  logic [DATA_W-1:0]                   s_rdata,
    input  logic [1:0]                          s_rresp,
    input  logic                                s_rvalid,
    output logic                                s_rready,
    // Slave-side write channels
    output logic [ADDR_W-1:0]                   s_awaddr,
    output logic                                s_awvalid,
    input  logic                                s_awready,
    output logic [DATA_W-1:0]                   s_wdata,
    output logic [(DATA_W/8)-1:0]               s_wstrb,
    output logic                                s_wvalid,
    input  logic                                s_wready,
    input  logic [1:0]                          s_bresp,
    input  logic                                s_bvalid,
    output logic                                s_bready,
    // Debug / status
    output logic [$clog2(NUM_MASTERS)-1:0]      grant,
    output logic                                busy
);

    localparam int unsigned GRANT_W = $clog2(NUM_MASTERS);
    localparam int unsigned STRB_W  = DATA_W / 8;

    typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StB} state_e;

    state_e               state_q;
    logic [GRANT_W-1:0]   grant_q;
    logic [GRANT_W-1:0]   rr_ptr_q;
    logic                 aw_done_q;
    logic                 w_done_q;
    logic                 busy_q;

    // Per-master views of the packed request buses
    logic [ADDR_W-1:0]    araddr_arr [NUM_MASTERS];
    logic [ADDR_W-1:0]    awaddr_arr [NUM_MASTERS];
    logic [DATA_W-1:0]    wdata_arr  [NUM_MASTERS];
    logic [STRB_W-1:0]    wstrb_arr  [NUM_MASTERS];

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
        assign araddr_arr[gi] = m_araddr[gi*ADDR_W +: ADDR_W];
        assign awaddr_arr[gi] = m_awaddr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi]  = m_wdata[gi*DATA_W +: DATA_W];
        assign wstrb_arr[gi]  = m_wstrb[gi*STRB_W +: STRB_W];
    end

    // Round-robin search: first requesting index at or above rr_ptr, wrapping.
    logic [NUM_MASTERS-1:0] req;
    logic                   arb_found;
    logic [GRANT_W-1:0]     arb_idx;
    logic [GRANT_W-1:0]     cand_idx;
    int unsigned            cand;

    always_comb begin
        req       = m_arvalid | m_awvalid;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand     = (32'(rr_ptr_q) + i) % NUM_MASTERS;
            cand_idx = GRANT_W'(cand);
            if (!arb_found && req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    logic [GRANT_W-1:0] next_ptr;
    assign next_ptr = (grant_q == GRANT_W'(NUM_MASTERS - 1)) ? '0 : grant_q + GRANT_W'(1);

    // Channel muxing: only the granted master's channel of the current state is connected.
    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_bresp   = '0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        unique case (state_q)
            StAr: begin
                s_araddr           = araddr_arr[grant_q];
                s_arvalid          = m_arvalid[grant_q];
                m_arready[grant_q] = s_arready;
            end
            StR: begin
                m_rvalid[grant_q] = s_rvalid;
                s_rready          = m_rready[grant_q];
                m_rdata           = s_rdata;
                m_rresp           = s_rresp;
            end
            StAw: begin
                // A channel that has already handshaken is masked off until B.
                s_awaddr           = awaddr_arr[grant_q];
                s_awvalid          = m_awvalid[grant_q] & ~aw_done_q;
                m_awready[grant_q] = s_awready & ~aw_done_q;
                s_wdata            = wdata_arr[grant_q];
                s_wstrb            = wstrb_arr[grant_q];
                s_wvalid           = m_wvalid[grant_q] & ~w_done_q;
                m_wready[grant_q]  = s_wready & ~w_done_q;
            end
            StB: begin
                m_bvalid[grant_q] = s_bvalid;
                s_bready          = m_bready[grant_q];
                m_bresp           = s_bresp;
            end
            default: ;
        endcase
    end

    logic aw_ok;
    logic w_ok;
    assign aw_ok = aw_done_q | (s_awvalid & s_awready);
    assign w_ok  = w_done_q  | (s_wvalid  & s_wready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arb_found) begin
                        grant_q <= arb_idx;
                        busy_q  <= 1'b1;
                        // Reads win over writes within one master.
                        state_q <= m_arvalid[arb_idx] ? StAr : StAw;
                    end
                end
                StAr: begin
                    if (s_arvalid && s_arready) begin
                        state_q <= StR;
                    end
                end
                StR: begin
                    if (s_rvalid && s_rready) begin
                        state_q  <= StIdle;
                        rr_ptr_q <= next_ptr;
                        busy_q   <= 1'b0;
                    end
                end
                StAw: begin
                    if (aw_ok && w_ok) begin
                        state_q   <= StB;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        aw_done_q <= aw_ok;
                        w_done_q  <= w_ok;
                    end
                end
                StB: begin
                    if (s_bvalid && s_bready) begin
                        state_q  <= StIdle;
                        rr_ptr_q <= next_ptr;
                        busy_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Self-checking bench for axi_lite_arbiter: two master drivers, a small AXI4-lite slave
// model, a reference memory for expected read data and per-master response scoreboards.
module tb_axi_lite_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NM*AW-1:0] m_araddr, m_awaddr;
    logic [NM*DW-1:0] m_wdata;
    logic [NM*SW-1:0] m_wstrb;
    logic [NM-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
    logic [NM-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [DW-1:0]    m_rdata;
    logic [1:0]       m_rresp, m_bresp;
    logic [AW-1:0]    s_araddr, s_awaddr;
    logic [DW-1:0]    s_rdata, s_wdata;
    logic [SW-1:0]    s_wstrb;
    logic [1:0]       s_rresp, s_bresp;
    logic             s_arvalid, s_arready, s_rvalid, s_rready;
    logic             s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic             grant;
    logic             busy;

    axi_lite_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant(grant), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave contents: one fixed word, everything else derived from the address.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1357_9bdf);
    endfunction

    // Error regions: 0xE... -> SLVERR, 0xF... -> DECERR.
    function automatic logic [1:0] resp_of(input logic [31:0] a);
        if (a[31:28] == 4'hF) return 2'b11;
        if (a[31:28] == 4'hE) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // ---------------- slave model ----------------
    int          slave_lat = 0;
    logic        r_pend, aw_got, w_got;
    int          rcnt;
    logic [31:0] raddr_l, waddr_l, wdata_l;
    logic [3:0]  wstrb_l;
    logic [31:0] smem   [32];
    logic [31:0] smem_v;

    function automatic logic [4:0] sidx(input logic [31:0] a);
        return {a[13:12], a[4:2]};
    endfunction
    function automatic logic [31:0] srd(input logic [31:0] a);
        return smem_v[sidx(a)] ? smem[sidx(a)] : dflt(a);
    endfunction

    assign s_arready = !r_pend && !s_rvalid;
    assign s_awready = !aw_got && !s_bvalid;
    assign s_wready  = !w_got && !s_bvalid;

    always @(posedge clk) begin
        if (!rst) begin
            r_pend <= 1'b0; rcnt <= 0; s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b0; s_bresp <= '0;
            raddr_l <= '0; waddr_l <= '0; wdata_l <= '0; wstrb_l <= '0; smem_v <= '0;
        end else begin
            if (s_rvalid && s_rready) s_rvalid <= 1'b0;
            if (s_arvalid && s_arready) begin
                raddr_l <= s_araddr;
                if (slave_lat == 0) begin
                    s_rvalid <= 1'b1; s_rdata <= srd(s_araddr); s_rresp <= resp_of(s_araddr);
                end else begin
                    r_pend <= 1'b1; rcnt <= slave_lat;
                end
            end else if (r_pend) begin
                if (rcnt == 1) begin
                    s_rvalid <= 1'b1; r_pend <= 1'b0;
                    s_rdata <= srd(raddr_l); s_rresp <= resp_of(raddr_l);
                end
                rcnt <= rcnt - 1;
            end
            if (s_awvalid && s_awready) begin aw_got <= 1'b1; waddr_l <= s_awaddr; end
            if (s_wvalid && s_wready) begin
                w_got <= 1'b1; wdata_l <= s_wdata; wstrb_l <= s_wstrb;
            end
            if (aw_got && w_got && !s_bvalid) begin
                smem[sidx(waddr_l)]   <= merge(srd(waddr_l), wdata_l, wstrb_l);
                smem_v[sidx(waddr_l)] <= 1'b1;
                s_bvalid <= 1'b1; s_bresp <= resp_of(waddr_l);
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (s_bvalid && s_bready) s_bvalid <= 1'b0;
        end
    end

    // ---------------- reference memory and scoreboards ----------------
    logic [31:0] ref_mem [logic [31:0]];
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    logic [33:0] exp_r_q [NM][$];
    logic [1:0]  exp_b_q [NM][$];
    logic        obs_g [$];
    int          r_cyc [NM];
    int          b_cyc [NM];
    int          r_cnt [NM];
    logic [31:0] last_rdata [NM];
    logic        busy_prev = 1'b0;
    logic [NM-1:0] mon_mask;
    logic [33:0] e_r;
    logic [1:0]  e_b;

    always @(negedge clk) begin
        for (int i = 0; i < NM; i++) begin
            if (m_rvalid[i] && m_rready[i]) begin
                r_cyc[i] = cyc; r_cnt[i]++; last_rdata[i] = m_rdata;
                if (exp_r_q[i].size() == 0) begin
                    chk("r_unexpected", 64'(i + 1), 64'(0));
                end else begin
                    e_r = exp_r_q[i].pop_front();
                    chk("r_data", 64'(m_rdata), 64'(e_r[33:2]));
                    chk("r_resp", 64'(m_rresp), 64'(e_r[1:0]));
                end
            end
            if (m_bvalid[i] && m_bready[i]) begin
                b_cyc[i] = cyc;
                if (exp_b_q[i].size() == 0) begin
                    chk("b_unexpected", 64'(i + 1), 64'(0));
                end else begin
                    e_b = exp_b_q[i].pop_front();
                    chk("b_resp", 64'(m_bresp), 64'(e_b));
                end
            end
        end
        if (busy && !busy_prev) obs_g.push_back(grant);
        busy_prev = busy;
        // Only the granted master may ever see a valid or ready.
        mon_mask = busy ? (NM'(1) << grant) : '0;
        chk("isolation", 64'((m_rvalid | m_arready | m_awready | m_wready | m_bvalid) & ~mon_mask),
            64'(0));
        if (!busy) begin
            chk("idle_slave_ctrl", 64'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}),
                64'(0));
            chk("idle_data", 64'({m_rdata, m_rresp, m_bresp}), 64'(0));
        end
    end

    // ---------------- master drivers ----------------
    function automatic bit hs_seen(input int kind, input int m);
        case (kind)
            0:       return m_arready[m];
            1:       return m_rvalid[m] & m_rready[m];
            2:       return m_awready[m];
            3:       return m_wready[m];
            default: return m_bvalid[m] & m_bready[m];
        endcase
    endfunction

    // Returns 1 ns after the clock edge on which the handshake completes.
    task automatic wait_hs(input int kind, input int m, input string name);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (hs_seen(kind, m)) begin
                @(posedge clk); #1;
                return;
            end
        end
        chk({name, "_timeout"}, 64'(1), 64'(0));
    endtask

    task automatic do_read(input int m, input logic [31:0] a, input logic [1:0] resp);
        exp_r_q[m].push_back({ref_rd(a), resp});
        m_rready[m] = 1'b1;
        m_araddr[m*AW +: AW] = a;
        m_arvalid[m] = 1'b1;
        wait_hs(0, m, "ar_hs");
        m_arvalid[m] = 1'b0;
        wait_hs(1, m, "r_hs");
        chk("busy_after_r", 64'(busy), 64'(0));
    endtask

    bit w_flag [NM];

    task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int wdel, input logic [1:0] resp);
        ref_mem[a] = merge(ref_rd(a), d, s);
        exp_b_q[m].push_back(resp);
        m_bready[m] = 1'b1;
        w_flag[m] = 1'b0;
        fork
            begin
                m_awaddr[m*AW +: AW] = a;
                m_awvalid[m] = 1'b1;
                wait_hs(2, m, "aw_hs");
                m_awvalid[m] = 1'b0;
                // Until W completes, AW stays quiet and B has not been entered.
                for (int n = 0; n < 400 && !w_flag[m]; n++) begin
                    @(negedge clk);
                    if (!w_flag[m])
                        chk("aw_done_hold", 64'({s_awvalid, m_awready[m], s_bready}), 64'(0));
                end
            end
            begin
                repeat (wdel) begin @(posedge clk); #1; end
                m_wdata[m*DW +: DW] = d;
                m_wstrb[m*SW +: SW] = s;
                m_wvalid[m] = 1'b1;
                wait_hs(3, m, "w_hs");
                m_wvalid[m] = 1'b0;
                w_flag[m] = 1'b1;
            end
        join
        wait_hs(4, m, "b_hs");
        chk("busy_after_b", 64'(busy), 64'(0));
    endtask

    typedef struct {
        int          m;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          wdel;
        logic [1:0]  resp;
    } vec_t;

    vec_t tbl [8];
    int   r_before;

    initial begin
        tbl[0] = '{0, 1'b1, 32'h8000_2000, 32'hcafe_f00d, 4'hF, 0, 2'b00};
        tbl[1] = '{1, 1'b0, 32'h8000_2000, 32'h0,         4'h0, 0, 2'b00};
        tbl[2] = '{1, 1'b1, 32'h8000_2000, 32'h1122_3344, 4'h5, 1, 2'b00};
        tbl[3] = '{0, 1'b0, 32'h8000_2000, 32'h0,         4'h0, 0, 2'b00};
        tbl[4] = '{0, 1'b0, 32'hE000_0010, 32'h0,         4'h0, 0, 2'b10};
        tbl[5] = '{1, 1'b1, 32'hF000_3008, 32'h0000_0001, 4'hF, 0, 2'b11};
        tbl[6] = '{1, 1'b0, 32'hF000_3008, 32'h0,         4'h0, 0, 2'b11};
        tbl[7] = '{0, 1'b0, 32'h8000_1000, 32'h0,         4'h0, 0, 2'b00};

        m_araddr = '0; m_arvalid = '0; m_rready = '0;
        m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0; m_wvalid = '0;
        m_bready = '0;
        for (int i = 0; i < NM; i++) begin r_cnt[i] = 0; r_cyc[i] = 0; b_cyc[i] = 0; end

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_grant", 64'(grant), 64'(0));
        chk("reset_handshakes", 64'({m_arready, m_rvalid, m_awready, m_wready, m_bvalid,
                                    s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}), 64'(0));
        chk("reset_data", 64'({s_araddr, m_rdata}), 64'(0));
        rst = 1'b1;

        // Both masters read in the first cycle after reset: 0 then 1.
        obs_g.delete();
        fork
            do_read(0, 32'h8000_0000, 2'b00);
            do_read(1, 32'h8000_0004, 2'b00);
        join
        chk("t2_count", 64'(obs_g.size()), 64'(2));
        for (int i = 0; i < 2 && i < obs_g.size(); i++) chk("t2_grant", 64'(obs_g[i]), 64'(i));

        // Continuous contention: grants must alternate.
        obs_g.delete();
        fork
            for (int k = 0; k < 3; k++) do_read(0, 32'h8000_0010 + 32'(k * 4), 2'b00);
            for (int k = 0; k < 3; k++) do_read(1, 32'h8000_0020 + 32'(k * 4), 2'b00);
        join
        chk("t3_count", 64'(obs_g.size()), 64'(6));
        for (int i = 0; i < 6 && i < obs_g.size(); i++)
            chk("t3_grant", 64'(obs_g[i]), 64'(i % 2));

        // Single read of the fixed word.
        do_read(0, 32'h8000_0000, 2'b00);
        chk("t1_rdata", 64'(last_rdata[0]), 64'h413);

        // Write on master 1 with W arriving two cycles after AW.
        do_write(1, 32'h8000_1000, 32'hdead_beef, 4'hF, 2, 2'b00);

        // Same-cycle read and write on master 0: read goes first.
        obs_g.delete();
        fork
            do_read(0, 32'h8000_1000, 2'b00);
            do_write(0, 32'h8000_2004, 32'h0bad_cafe, 4'hF, 0, 2'b00);
        join
        chk("t5_count", 64'(obs_g.size()), 64'(2));
        for (int i = 0; i < 2 && i < obs_g.size(); i++) chk("t5_grant", 64'(obs_g[i]), 64'(0));
        chk("t5_read_first", 64'(r_cyc[0] < b_cyc[0]), 64'(1));

        // Vector table: partial strobes and forwarded error responses.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].wr)
                do_write(tbl[i].m, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].wdel, tbl[i].resp);
            else
                do_read(tbl[i].m, tbl[i].addr, tbl[i].resp);
        end
        chk("tbl_merged", 64'(last_rdata[0] == 32'hdead_beef), 64'(1));

        // Reset while waiting in R: no response must ever reach the master.
        slave_lat = 8;
        m_rready[1] = 1'b1;
        m_araddr[1*AW +: AW] = 32'h8000_0008;
        m_arvalid[1] = 1'b1;
        wait_hs(0, 1, "t6_ar");
        m_arvalid[1] = 1'b0;
        chk("t6_in_r", 64'({busy, s_rready, s_rvalid}), 64'(3'b110));
        r_before = r_cnt[1];
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_grant", 64'(grant), 64'(0));
        chk("t6_handshakes", 64'({m_arready, m_rvalid, m_awready, m_wready, m_bvalid,
                                 s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}), 64'(0));
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("t6_no_r", 64'(r_cnt[1]), 64'(r_before));
        chk("t6_idle", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

endmodule
